// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a byte stream (16-bit word count, big-endian
// words, XOR checksum), writes each word to IMEM and holds the CPU until the load is good.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        IM_WE,
  output logic [31:0] IM_ADDR,
  output logic [31:0] IM_DATA,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] hold_q, hold_d;
  logic        im_we_q, im_we_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_data_q, im_data_d;
  logic        byte_ready_q, byte_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer_s;
  logic [15:0] hdr_count_s;
  logic [15:0] word_idx_inc_s;

  assign xfer_s         = byte_valid & byte_ready_q;
  assign hdr_count_s    = {count_q[15:8], byte_data};
  assign word_idx_inc_s = word_idx_q + 16'd1;

  // Next-state, stream parsing and word assembly.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;

    case (state_q)
      HDR_HI: begin
        if (xfer_s) begin
          count_d = {byte_data, 8'h00};
          state_d = HDR_LO;
        end else begin
          state_d = HDR_HI;
        end
      end
      HDR_LO: begin
        if (xfer_s) begin
          count_d = hdr_count_s;
          if ({1'b0, hdr_count_s} > MAX_W) begin
            state_d = ERROR;
          end else if (hdr_count_s == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = HDR_LO;
        end
      end
      DATA: begin
        if (xfer_s) begin
          csum_d     = csum_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: hold_d[23:16] = byte_data;
            2'd1: hold_d[15:8]  = byte_data;
            2'd2: hold_d[7:0]   = byte_data;
            2'd3: begin
              // The write is registered, so the next word's byte 0 can land in hold
              // while this word's IM_WE pulse is still on the bus.
              im_we_d    = 1'b1;
              im_data_d  = {hold_q, byte_data};
              im_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              word_idx_d = word_idx_inc_s;
              if (word_idx_inc_s == count_q) begin
                state_d = CHECK;
              end else begin
                state_d = DATA;
              end
            end
            default: hold_d = hold_q;
          endcase
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
        if (xfer_s) begin
          if (byte_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = CHECK;
        end
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    byte_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                   (state_d == DATA)   || (state_d == CHECK);
    cpu_hold_d   = (state_d != DONE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HDR_HI;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= 16'd0;
      count_q      <= 16'd0;
      csum_q       <= 8'h00;
      hold_q       <= 24'd0;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE_ADDR;
      im_data_q    <= 32'd0;
      byte_ready_q <= 1'b1;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      count_q      <= count_d;
      csum_q       <= csum_d;
      hold_q       <= hold_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_data_q    <= im_data_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign IM_WE      = im_we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_DATA    = im_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams plus randomized streams and
// byte_valid gaps, checked against a stream-level reference model.
module tb_imem_loader;

  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, im_we, cpu_hold, done, error;
  logic [31:0] im_addr, im_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic        exp_done, exp_err;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .IM_WE(im_we), .IM_ADDR(im_addr), .IM_DATA(im_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Log every cycle with the write strobe high.
  always @(negedge clk) begin
    if (im_we === 1'b1) got_q.push_back({im_addr, im_data});
  end

  // Stream-level model: what a loader must write and conclude for stim_q.
  task automatic model_stream();
    int n, p;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    x = 8'h00;
    if (stim_q.size() < 2) return;
    n = {stim_q[0], stim_q[1]};
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      p = 2 + 4 * i;
      if (p + 3 >= stim_q.size()) return;
      exp_q.push_back({BASE + 32'(4 * i), stim_q[p], stim_q[p+1], stim_q[p+2], stim_q[p+3]});
      x = x ^ stim_q[p] ^ stim_q[p+1] ^ stim_q[p+2] ^ stim_q[p+3];
    end
    p = 2 + 4 * n;
    if (p < stim_q.size()) begin
      exp_done = (stim_q[p] == x);
      exp_err  = !exp_done;
    end
  endtask

  task automatic send_stream(input int max_gap);
    for (int i = 0; i < stim_q.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stim_q[i];
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_good_stream(input logic [7:0] csum);
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10, csum};
  endtask

  task automatic test_reset();
    // A byte offered during reset must not be taken as the count high byte.
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h05;
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    got_q.delete();
    total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", byte_ready); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", done, error); end
    total++; if (im_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", im_we); end
    total++; if (im_addr !== BASE || im_data !== 32'h0) begin bad++; $display("FAIL rst_addr_data got=%h/%h exp=%h/0", im_addr, im_data, BASE); end
    stim_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL rst_prio got=%b%b exp=10", done, error); end
  endtask

  task automatic test_good_stream();
    do_reset();
    got_q.delete();
    load_good_stream(8'h99);  // XOR of the eight data bytes
    send_stream(0);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL good_nwr got=%0d exp=2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {32'h0, 32'h20080005}) begin bad++; $display("FAIL good_w0 got=%h exp=%h", got_q[0], {32'h0, 32'h20080005}); end
      total++; if (got_q[1] !== {32'h4, 32'hAC080010}) begin bad++; $display("FAIL good_w1 got=%h exp=%h", got_q[1], {32'h4, 32'hAC080010}); end
    end
    total++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL good_flags got d=%b e=%b h=%b r=%b exp 1 0 0 0", done, error, cpu_hold, byte_ready); end
    total++; if (im_addr !== 32'h4 || im_data !== 32'hAC080010) begin bad++; $display("FAIL good_stable got=%h/%h exp=4/ac080010", im_addr, im_data); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    got_q.delete();
    load_good_stream(8'h8D);
    send_stream(0);
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL badck_nwr got=%0d exp=2", got_q.size()); end
    else begin
      total++; if (got_q[1] !== {32'h4, 32'hAC080010}) begin bad++; $display("FAIL badck_w1 got=%h exp=%h", got_q[1], {32'h4, 32'hAC080010}); end
    end
    total++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL badck_flags got e=%b d=%b h=%b r=%b exp 1 0 1 0", error, done, cpu_hold, byte_ready); end
  endtask

  task automatic test_zero_count();
    do_reset();
    got_q.delete();
    stim_q = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    total++; if (got_q.size() !== 0 || done !== 1'b1) begin bad++; $display("FAIL zero_ok got nwr=%0d d=%b exp 0 1", got_q.size(), done); end
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h01};
    send_stream(0);
    total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_bad got e=%b d=%b exp 1 0", error, done); end
  endtask

  task automatic test_over_max();
    do_reset();
    got_q.delete();
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'h01;
    @(negedge clk); byte_data = 8'h01;
    @(negedge clk); byte_valid = 1'b0;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL over_err got=%b exp=1", error); end
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_stream(1);
    total++; if (got_q.size() !== 0 || error !== 1'b1 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL over_term got nwr=%0d e=%b r=%b exp 0 1 0", got_q.size(), error, byte_ready); end
    // Exactly MAX_WORDS is still a legal count.
    do_reset();
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'h01;
    @(negedge clk); byte_data = 8'h00;
    @(negedge clk); byte_valid = 1'b0;
    total++; if (error !== 1'b0 || byte_ready !== 1'b1) begin bad++; $display("FAIL max_ok got e=%b r=%b exp 0 1", error, byte_ready); end
  endtask

  task automatic test_gaps();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      got_q.delete();
      load_good_stream(8'h99);
      model_stream();
      send_stream(5);
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL gaps_nwr got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL gaps_w%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (done !== exp_done || error !== exp_err) begin bad++; $display("FAIL gaps_res got=%b%b exp=%b%b", done, error, exp_done, exp_err); end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] x;
    for (int r = 0; r < 12; r++) begin
      do_reset();
      got_q.delete();
      n = ($urandom_range(5, 0) == 0) ? $urandom_range(400, MAXW + 1) : $urandom_range(6, 0);
      stim_q.delete();
      stim_q.push_back(8'(n >> 8));
      stim_q.push_back(8'(n));
      x = 8'h00;
      if (n <= MAXW) begin
        for (int i = 0; i < 4 * n; i++) begin
          stim_q.push_back(8'($urandom));
          x = x ^ stim_q[stim_q.size() - 1];
        end
        stim_q.push_back(($urandom_range(3, 0) == 0) ? 8'($urandom) : x);
      end else begin
        stim_q.push_back(8'($urandom));
        stim_q.push_back(8'($urandom));
      end
      model_stream();
      send_stream(2);
      total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_nwr got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_w%0d got=%h exp=%h", r, i, got_q[i], exp_q[i]); end
      end
      total++; if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done || byte_ready !== !(exp_done | exp_err)) begin
        bad++; $display("FAIL rnd%0d_res got d=%b e=%b h=%b r=%b exp d=%b e=%b", r, done, error, cpu_hold, byte_ready, exp_done, exp_err); end
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    got_q.delete();
    stim_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08};
    send_stream(0);
    do_reset();
    load_good_stream(8'h99);
    send_stream(0);
    total++; if (got_q.size() !== 3) begin bad++; $display("FAIL midrst_nwr got=%0d exp=3", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {32'h0, 32'h20080005} || got_q[1] !== {32'h0, 32'h20080005} || got_q[2] !== {32'h4, 32'hAC080010}) begin
        bad++; $display("FAIL midrst_wr got=%h %h %h", got_q[0], got_q[1], got_q[2]); end
    end
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL midrst_res got=%b%b exp=10", done, error); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_good_stream();
    test_bad_checksum();
    test_zero_count();
    test_over_max();
    test_gaps();
    test_random();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
